// File: rtl/alu_pair_stim_checker.sv
// Stimulus generator and checker for the dual-ALU compare macro: LFSR-driven operand vectors out,
// compare results in, checked against an internal reference ALU pair with a latency-matched pipeline.
module alu_pair_stim_checker #(
  parameter int          CNT_W     = 16,
  parameter int          DUT_LAT   = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             mirror_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [19:0]      stim_o,
  input  logic [3:0]       dut_x_i,
  input  logic             dut_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] first_fail_o
);

  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
  localparam int               DW        = $clog2(DUT_LAT + 2);
  localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reference 4-bit ALU; returns {carry, out}.
  function automatic logic [4:0] ref_alu(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (sel)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = {1'b0, a & b};
      2'b11:   r = {1'b0, a ^ b};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] n;
    n = {1'b0, l[31:1]};
    if (l[0]) begin
      n = n ^ LFSR_TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

  state_t             state_r, state_next;
  logic [31:0]        lfsr_r;
  logic [19:0]        stim_r;
  logic [CNT_W-1:0]   vec_idx_r, num_vec_r;
  logic               mirror_r;
  logic [DW-1:0]      drain_cnt_r;
  logic               busy_r, done_r, pass_r;
  logic [CNT_W-1:0]   err_cnt_r, first_fail_r;
  logic [CNT_W-1:0]   err_next_s, first_fail_next_s;
  // Stage 0 lines up with stim_o; stage DUT_LAT lines up with the macro's answer for that vector.
  logic [DUT_LAT:0]   pv_r;
  logic [4:0]         pexp_r [0:DUT_LAT];
  logic [CNT_W-1:0]   pidx_r [0:DUT_LAT];

  logic [19:0]        vec_s;
  logic [4:0]         r1_s, r2_s, exp_s;
  logic               start_go_s, last_vec_s, mismatch_s;

  // Vector build from current LFSR state and its expected {x,y}.
  always_comb begin
    vec_s = lfsr_r[19:0];
    if (mirror_r) begin
      vec_s[11:8]  = lfsr_r[3:0];
      vec_s[15:12] = lfsr_r[7:4];
      vec_s[19:18] = lfsr_r[17:16];
    end else begin
      vec_s = lfsr_r[19:0];
    end
    r1_s  = ref_alu(vec_s[17:16], vec_s[3:0], vec_s[7:4]);
    r2_s  = ref_alu(vec_s[19:18], vec_s[11:8], vec_s[15:12]);
    exp_s = {r1_s[3:0] ^ r2_s[3:0], r1_s[4] ^ r2_s[4]};
  end

  assign start_go_s = start_i && ((state_r == IDLE) || (state_r == DONE));
  assign last_vec_s = (vec_idx_r == (num_vec_r - CNT_W'(1)));
  assign mismatch_s = pv_r[DUT_LAT] && ({dut_x_i, dut_y_i} != pexp_r[DUT_LAT]);

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_next = (num_vec_i == '0) ? DONE : RUN;
        end else begin
          state_next = state_r;
        end
      end
      RUN: begin
        if (last_vec_s) begin
          state_next = DRAIN;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == DW'(DUT_LAT)) begin
          state_next = DONE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Error counter and first-fail index updates; a new run clears both.
  always_comb begin
    err_next_s        = err_cnt_r;
    first_fail_next_s = first_fail_r;
    if (start_go_s) begin
      err_next_s        = '0;
      first_fail_next_s = ALL_ONES;
    end else if (mismatch_s) begin
      err_next_s        = (err_cnt_r == ALL_ONES) ? err_cnt_r : err_cnt_r + CNT_W'(1);
      first_fail_next_s = (first_fail_r == ALL_ONES) ? pidx_r[DUT_LAT] : first_fail_r;
    end else begin
      err_next_s        = err_cnt_r;
      first_fail_next_s = first_fail_r;
    end
  end

  // State register and status flags, registered from next-state so they track the FSM exactly.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= '0;
      first_fail_r <= ALL_ONES;
    end else begin
      state_r      <= state_next;
      busy_r       <= (state_next == RUN) || (state_next == DRAIN);
      done_r       <= (state_next == DONE);
      pass_r       <= (state_next == DONE) && (err_next_s == '0);
      err_cnt_r    <= err_next_s;
      first_fail_r <= first_fail_next_s;
    end
  end

  // Run control: operand latch, LFSR advance (only on issued vectors), stimulus and drain timer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lfsr_r      <= LFSR_SEED;
      stim_r      <= 20'd0;
      vec_idx_r   <= '0;
      num_vec_r   <= '0;
      mirror_r    <= 1'b0;
      drain_cnt_r <= '0;
    end else if (start_go_s) begin
      lfsr_r      <= LFSR_SEED;
      vec_idx_r   <= '0;
      num_vec_r   <= num_vec_i;
      mirror_r    <= mirror_i;
      drain_cnt_r <= '0;
    end else if (state_r == RUN) begin
      stim_r      <= vec_s;
      lfsr_r      <= lfsr_step(lfsr_r);
      vec_idx_r   <= vec_idx_r + CNT_W'(1);
      drain_cnt_r <= '0;
    end else if (state_r == DRAIN) begin
      drain_cnt_r <= drain_cnt_r + DW'(1);
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  // Expected-value pipeline; bubbles are pushed whenever no vector is issued.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pv_r <= '0;
      for (int i = 0; i <= DUT_LAT; i++) begin
        pexp_r[i] <= 5'd0;
        pidx_r[i] <= '0;
      end
    end else begin
      pv_r      <= {pv_r[DUT_LAT-1:0], (state_r == RUN)};
      pexp_r[0] <= exp_s;
      pidx_r[0] <= vec_idx_r;
      for (int i = 1; i <= DUT_LAT; i++) begin
        pexp_r[i] <= pexp_r[i-1];
        pidx_r[i] <= pidx_r[i-1];
      end
    end
  end

  assign stim_o       = stim_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign pass_o       = pass_r;
  assign err_cnt_o    = err_cnt_r;
  assign first_fail_o = first_fail_r;

endmodule

// File: tb/tb_alu_pair_stim_checker.sv
// Self-checking bench: a registered behavioural model of the compare macro closes the loop, and
// every run is predicted from the LFSR/ALU rules computed with plain arithmetic.
module tb_alu_pair_stim_checker;
  localparam int          CNT_W   = 16;
  localparam int          DUT_LAT = 1;
  localparam logic [31:0] SEED    = 32'hACE1_1234;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             mirror_i = 1'b0;
  logic [CNT_W-1:0] num_vec_i = '0;
  logic [19:0]      stim_o;
  logic [3:0]       dut_x = 4'd0;
  logic             dut_y = 1'b0;
  logic             busy_o, done_o, pass_o;
  logic [CNT_W-1:0] err_cnt_o, first_fail_o;

  int n_cmp = 0;
  int n_err = 0;

  // Macro-model fault controls and bookkeeping.
  logic             stuck_x = 1'b0;
  logic             inj_en  = 1'b0;
  int               inj_idx = 0;
  logic [CNT_W-1:0] bcnt;
  logic [4:0]       model_xy;
  logic [19:0]      seen_q[$];

  alu_pair_stim_checker #(.CNT_W(CNT_W), .DUT_LAT(DUT_LAT), .LFSR_SEED(SEED)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .mirror_i(mirror_i),
    .num_vec_i(num_vec_i), .stim_o(stim_o), .dut_x_i(dut_x), .dut_y_i(dut_y),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_fail_o(first_fail_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(input int sel, input int a, input int b);
    int res, c;
    case (sel)
      0:       begin res = a + b; c = (res > 15) ? 1 : 0; end
      1:       begin res = a - b; c = (a < b) ? 1 : 0;    end
      2:       begin res = a & b; c = 0;                   end
      default: begin res = a ^ b; c = 0;                   end
    endcase
    return 5'((c * 16) + (res & 15));
  endfunction

  function automatic logic [4:0] pair_xy(input logic [19:0] v);
    logic [4:0] r1, r2;
    r1 = alu_ref(int'(v[17:16]), int'(v[3:0]), int'(v[7:4]));
    r2 = alu_ref(int'(v[19:18]), int'(v[11:8]), int'(v[15:12]));
    return {r1[3:0] ^ r2[3:0], r1[4] ^ r2[4]};
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l % 2 == 1) ? ((l / 2) ^ 32'h8020_0003) : (l / 2);
  endfunction

  function automatic logic [19:0] make_vec(input logic [31:0] l, input bit m);
    logic [19:0] v;
    v = l[19:0];
    if (m) v = {v[17:16], v[17:16], v[7:4], v[3:0], v[7:4], v[3:0]};
    return v;
  endfunction

  // Registered macro model (DUT_LAT = 1) with optional stuck-x and single-vector y flip.
  assign model_xy = pair_xy(stim_o);
  always @(posedge clk) begin
    if (start_i) bcnt <= '0;
    else if (busy_o) bcnt <= bcnt + 16'd1;
    dut_x <= stuck_x ? 4'hF : model_xy[4:1];
    dut_y <= model_xy[0] ^ (inj_en && (int'(bcnt) == inj_idx + 1));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Launch a run and wait for done; optionally pulse start again at step ign_at mid-run.
  task automatic run(input int n, input bit m, input int ign_at, output int cyc);
    seen_q.delete();
    @(negedge clk);
    num_vec_i = CNT_W'(n);
    mirror_i  = m;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    for (int k = 0; k <= n + DUT_LAT + 10; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      cyc = k;
      if (k == ign_at) begin
        start_i = 1'b1; num_vec_i = CNT_W'(9); mirror_i = ~m;
      end else begin
        start_i = 1'b0;
      end
      if (k >= 1 && k <= n && n <= 512) seen_q.push_back(stim_o);
      if (done_o === 1'b1) break;
    end
    start_i = 1'b0;
  endtask

  // Run n vectors and check timing, stimulus sequence and the final verdict against the model.
  task automatic check_run(input string tag, input int n, input bit m, input int ign_at);
    int          cyc, err, ff;
    logic [31:0] l;
    logic [19:0] v;
    logic [4:0]  expv, obs;
    run(n, m, ign_at, cyc);
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_cycles"}, 32'(cyc), (n == 0) ? 32'd0 : 32'(n + DUT_LAT + 1));
    l = SEED; err = 0; ff = 32'hFFFF;
    for (int k = 0; k < n; k++) begin
      v    = make_vec(l, m);
      expv = m ? 5'd0 : pair_xy(v);
      obs  = {stuck_x ? 4'hF : expv[4:1], expv[0] ^ (inj_en && k == inj_idx)};
      if (obs != expv) begin
        if (err < 32'hFFFF) err++;
        if (ff == 32'hFFFF) ff = k;
      end
      if (n <= 512 && k < seen_q.size()) check($sformatf("%s_stim%0d", tag, k), 32'(seen_q[k]), 32'(v));
      l = lfsr_next(l);
    end
    if (n <= 512) check({tag, "_nvec"}, 32'(seen_q.size()), 32'(n));
    check({tag, "_err"}, 32'(err_cnt_o), 32'(err));
    check({tag, "_ff"}, 32'(first_fail_o), 32'(ff));
    check({tag, "_pass"}, 32'(pass_o), (err == 0) ? 32'd1 : 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [19:0] hold;
    int          n, cyc;
    bit          m;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stim", 32'(stim_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_err", 32'(err_cnt_o), 32'd0);
    check("rst_ff", 32'(first_fail_o), 32'hFFFF);

    check_run("t1", 4, 1'b1, -1);

    inj_en = 1'b1; inj_idx = 2;
    check_run("t2", 8, 1'b1, -1);
    check("t2_err_is1", 32'(err_cnt_o), 32'd1);
    check("t2_ff_is2", 32'(first_fail_o), 32'd2);
    inj_en = 1'b0;

    check_run("t3", 256, 1'b0, -1);
    if (seen_q.size() > 0) check("t3_vec0", 32'(seen_q[0]), 32'h11234);
    else check("t3_vec0_present", 32'(seen_q.size()), 32'd256);

    hold = stim_o;
    check_run("t4", 0, 1'b0, -1);
    check("t4_stim_hold", 32'(stim_o), 32'(hold));

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 40);
      m = 1'($urandom_range(0, 1));
      inj_en  = 1'($urandom_range(0, 1));
      inj_idx = $urandom_range(0, n - 1);
      check_run($sformatf("rnd%0d", r), n, m, -1);
    end
    inj_en = 1'b0;

    // Reset in the middle of a run, then restart; a start pulse during the restart is ignored.
    @(negedge clk);
    num_vec_i = 16'd20; mirror_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy_before_rst", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_stim", 32'(stim_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_err", 32'(err_cnt_o), 32'd0);
    check("t6_rst_ff", 32'(first_fail_o), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    check_run("t6", 4, 1'b1, 2);

    stuck_x = 1'b1;
    check_run("t5", 32'hFFFF, 1'b1, -1);
    check("t5_err_sat", 32'(err_cnt_o), 32'hFFFF);
    check("t5_ff0", 32'(first_fail_o), 32'd0);
    stuck_x = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
